mult_pipe_n: RTL and testbench

- Parametrised, pipelined WIDTH×WIDTH integer multiplier with a valid/ready streaming handshake on both input and output.
- Successor to the fixed 18-bit single-shot multiplier leaf used under the Karatsuba tree.
- Adds per-operation signed/unsigned mode, configurable latency, full backpressure with bubble collapsing, a pass-through tag, and a delivered-result counter.
- Sits as the leaf multiplier under the Karatsuba recursion levels.

---
 rtl/mult_pipe_n.sv | 116 +++++++++++
 tb/tb_mult_pipe_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_n.sv
// Pipelined WIDTH x WIDTH signed/unsigned multiplier with valid/ready handshakes.
// It has LAT register stages, collapses bubbles, carries a tag with each operation and counts delivered results.
module mult_pipe_n #(
  parameter int WIDTH = 18,
  parameter int LAT   = 3,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy,
  output logic [CNT_W-1:0]   res_cnt,
  input  logic               clr_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LAT-1:0]   valid_reg;
  logic [LAT-1:0]   load;
  logic             chain_free;
  logic [PW-1:0]    prod_reg [LAT];
  logic [TAG_W-1:0] tag_reg  [LAT];
  logic [WIDTH:0]   opa_reg;
  logic [WIDTH:0]   opb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             deliver;

  // The top bit is the operand's sign when the operation is signed and 0 when it is unsigned.
  function automatic logic [WIDTH:0] tag_sign(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // A product truncated to PW bits is exact for both modes because the true result always fits.
  function automatic logic [PW-1:0] mul_ext(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = {{(WIDTH-1){x[WIDTH]}}, x};
    ye = {{(WIDTH-1){y[WIDTH]}}, y};
    return xe * ye;
  endfunction

  // A stage may load when it is empty or when its contents move downstream this cycle.
  always_comb begin
    load       = '0;
    chain_free = out_ready;
    for (int i = LAT - 1; i >= 0; i--) begin
      load[i]    = ~valid_reg[i] | (valid_reg[i] & chain_free);
      chain_free = load[i];
    end
  end

  assign in_ready  = load[0] & ~rst;
  assign out_valid = valid_reg[LAT-1];
  assign out_p     = prod_reg[LAT-1];
  assign out_tag   = tag_reg[LAT-1];
  assign busy      = |valid_reg;
  assign res_cnt   = cnt_reg;
  assign deliver   = valid_reg[LAT-1] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      for (int i = 0; i < LAT; i++) begin
        prod_reg[i] <= '0;
        tag_reg[i]  <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_reg[0] <= in_valid;
        if (in_valid) begin
          tag_reg[0] <= in_tag;
          // With a single stage, the multiply has to sit in front of the only register.
          if (LAT == 1) begin
            prod_reg[0] <= mul_ext(tag_sign(a, in_signed), tag_sign(b, in_signed));
          end else begin
            opa_reg <= tag_sign(a, in_signed);
            opb_reg <= tag_sign(b, in_signed);
          end
        end
      end
      for (int i = 1; i < LAT; i++) begin
        if (load[i]) begin
          valid_reg[i] <= valid_reg[i-1];
          if (valid_reg[i-1]) begin
            tag_reg[i]  <= tag_reg[i-1];
            prod_reg[i] <= (i == 1) ? mul_ext(opa_reg, opb_reg) : prod_reg[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr_cnt) begin
      cnt_reg <= '0;
    end else if (deliver && cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_pipe_n.sv
// Scoreboard bench for mult_pipe_n: the driver queues expected results and a monitor checks every delivery.
// The directed vectors cover latency, signed and unsigned corners, backpressure, reset and counter saturation.
module tb_mult_pipe_n;
  localparam int W   = 18;
  localparam int LAT = 3;
  localparam int TW  = 4;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            in_signed;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_p;
  logic [TW-1:0]   out_tag;
  logic            busy;
  logic [CW-1:0]   res_cnt;
  logic            clr_cnt;

  always #5 clk = ~clk;

  mult_pipe_n #(.WIDTH(W), .LAT(LAT), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .busy(busy), .res_cnt(res_cnt), .clr_cnt(clr_cnt)
  );

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [TW-1:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Operands, modes and products for the backpressure stream, worked out by hand.
  logic [W-1:0]   st_a [6] = '{18'h00003, 18'h00010, 18'h3FFFE, 18'h00100, 18'h20000, 18'h3FFFF};
  logic [W-1:0]   st_b [6] = '{18'h00007, 18'h00010, 18'h00003, 18'h00200, 18'h00002, 18'h3FFFF};
  logic           st_s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [2*W-1:0] st_p [6] = '{36'h000000015, 36'h000000100, 36'hFFFFFFFFA,
                               36'h000020000, 36'h000040000, 36'h000000001};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // A result is delivered on the next rising edge whenever out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual tag=%0h p=%0h required none", out_tag, out_p);
      end else begin
        e = sb.pop_front();
        $display("deliver tag=%0h p=%0h", out_tag, out_p);
        check("out_p", 64'(out_p), 64'(e.p));
        check("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                      input logic [TW-1:0] tt, input logic [2*W-1:0] ep);
    exp_t e;
    int   n;
    a = ta; b = tb; in_signed = ts; in_tag = tt; in_valid = 1'b1;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 60) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 required 1 tag=%0h", tt);
      in_valid = 1'b0;
    end else begin
      e.p = ep;
      e.tag = tt;
      sb.push_back(e);
      $display("issue tag=%0h a=%0h b=%0h signed=%0d expect=%0h", tt, ta, tb, ts, ep);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic clear_cnt();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check("clr_cnt", 64'(res_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_res_cnt", 64'(res_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Latency: with LAT=3, the result is visible after the second edge following acceptance.
    send(18'h3FFFF, 18'h3FFFF, 1'b0, 4'd1, 36'hFFFF80001);
    wait_valid(e);
    check("latency", 64'(e), 64'(LAT - 1));
    check("lat_tag", 64'(out_tag), 64'd1);
    drain();

    // The same operands in signed and then unsigned mode, back to back; the results must appear on consecutive cycles.
    send(18'h3FFFF, 18'h00005, 1'b1, 4'd2, 36'hFFFFFFFFB);
    send(18'h3FFFF, 18'h00005, 1'b0, 4'd3, 36'h00013FFFB);
    wait_valid(e);
    check("b2b_first_tag", 64'(out_tag), 64'd2);
    @(posedge clk);
    #1;
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_tag", 64'(out_tag), 64'd3);
    drain();

    // Signed corner cases and mixed modes.
    send(18'h20000, 18'h20000, 1'b1, 4'd4, 36'h400000000);
    send(18'h20000, 18'h1FFFF, 1'b1, 4'd5, 36'hC00020000);
    send(18'h20000, 18'h1FFFF, 1'b0, 4'd6, 36'h3FFFE0000);
    send(18'h00001, 18'h3FFFF, 1'b1, 4'd7, 36'hFFFFFFFFF);
    send(18'h00000, 18'h3FFFF, 1'b0, 4'd8, 36'h000000000);
    drain();

    // Backpressure: hold the first result for five cycles while the stream keeps pushing.
    clear_cnt();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(st_a[k], st_b[k], st_s[k], TW'(k), st_p[k]);
      end
      begin
        int ev;
        wait_valid(ev);
        for (int c = 0; c < 5; c++) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_p", 64'(out_p), 64'(st_p[0]));
          check("stall_tag", 64'(out_tag), 64'd0);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_res_cnt", 64'(res_cnt), 64'd6);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with two operations in flight; neither may ever come out.
    send(18'h00002, 18'h00002, 1'b0, 4'd9, 36'h4);
    send(18'h00003, 18'h00003, 1'b0, 4'd10, 36'h9);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_res_cnt", 64'(res_cnt), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("midrst_in_ready_back", 64'(in_ready), 64'd1);
    send(18'h00003, 18'h00005, 1'b0, 4'd11, 36'hF);
    wait_valid(e);
    check("post_rst_latency", 64'(e), 64'(LAT - 1));
    drain();
    check("post_rst_res_cnt", 64'(res_cnt), 64'd1);

    // Counter saturation, then a clear that coincides with a delivery.
    clear_cnt();
    for (int k = 0; k < 20; k++) send(W'(k), 18'h3, 1'b0, TW'(k), 36'(k * 3));
    drain();
    check("sat_res_cnt", 64'(res_cnt), 64'd15);
    send(18'h00006, 18'h00007, 1'b0, 4'd12, 36'h2A);
    wait_valid(e);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    check("clr_with_deliver", 64'(res_cnt), 64'd0);
    check("clr_delivered", 64'(out_valid), 64'd0);
    send(18'h00002, 18'h00002, 1'b0, 4'd13, 36'h4);
    drain();
    check("count_after_clr", 64'(res_cnt), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
